// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the core's load/store port: funct3 size codes,
// responder FSM encoding and the captured request payload.
package riscv_mem_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [2:0]      size;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a word-organised RAM: byte enables, replicated store
// word, extended load result and a flag for misaligned/illegal accesses.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]      i_addr_lo,
  input  logic [2:0]      i_size,
  input  logic            i_we,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rword,
  output logic [3:0]      o_be_c,
  output logic [XLEN-1:0] o_wword_c,
  output logic [XLEN-1:0] o_rdata_c,
  output logic            o_bad_c
);

  logic [XLEN-1:0] w_shifted;

  always_comb begin
    o_be_c    = 4'b0000;
    o_wword_c = i_wdata;
    o_rdata_c = '0;
    o_bad_c   = 1'b0;
    w_shifted = i_rword >> {i_addr_lo, 3'b000};

    // Store data is replicated across lanes; the byte enables pick the live lane(s).
    case (i_size)
      SZ_B, SZ_BU: begin
        o_be_c    = 4'b0001 << i_addr_lo;
        o_wword_c = {4{i_wdata[7:0]}};
        o_rdata_c = (i_size == SZ_B) ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                     : {24'b0, w_shifted[7:0]};
      end
      SZ_H, SZ_HU: begin
        o_be_c    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword_c = {2{i_wdata[15:0]}};
        o_rdata_c = (i_size == SZ_H) ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                     : {16'b0, w_shifted[15:0]};
        o_bad_c   = i_addr_lo[0];
      end
      SZ_W: begin
        o_be_c    = 4'b1111;
        o_wword_c = i_wdata;
        o_rdata_c = i_rword;
        o_bad_c   = |i_addr_lo;
      end
      default: o_bad_c = 1'b1;
    endcase

    if (i_we && ((i_size == SZ_BU) || (i_size == SZ_HU))) begin
      o_bad_c = 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port: one request at a time,
// programmable wait states, internal word RAM, held response until accepted.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_size,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned IW = XLEN - 2;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  mem_req_t        r_req, w_req_nx;
  logic            r_req_ready, w_req_ready_nx;
  logic            r_rsp_valid, w_rsp_valid_nx;
  logic [XLEN-1:0] r_rsp_rdata, w_rsp_rdata_nx;
  logic            r_rsp_err, w_rsp_err_nx;
  logic            w_mem_we;

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  logic [AW-1:0]   w_idx;
  logic            w_in_range;
  logic [XLEN-1:0] w_rword;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wword;
  logic [XLEN-1:0] w_rdata;
  logic            w_bad;
  logic            w_err;

  assign w_idx      = r_req.addr[AW+1:2];
  assign w_in_range = r_req.addr[XLEN-1:2] < IW'(DEPTH_WORDS);
  assign w_rword    = w_in_range ? r_mem[w_idx] : '0;
  assign w_err      = w_bad | ~w_in_range;

  mem_lane_align u_align (
    .i_addr_lo (r_req.addr[1:0]),
    .i_size    (r_req.size),
    .i_we      (r_req.we),
    .i_wdata   (r_req.wdata),
    .i_rword   (w_rword),
    .o_be_c    (w_be),
    .o_wword_c (w_wword),
    .o_rdata_c (w_rdata),
    .o_bad_c   (w_bad)
  );

  // State and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_req       <= w_req_nx;
      r_req_ready <= w_req_ready_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_rsp_rdata <= w_rsp_rdata_nx;
      r_rsp_err   <= w_rsp_err_nx;
    end
  end

  // Next-state logic. The WAIT counter starts at WAIT_CYCLES because the
  // capture edge itself is one cycle before the captured fields are usable.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_req_nx       = r_req;
    w_req_ready_nx = r_req_ready;
    w_rsp_valid_nx = r_rsp_valid;
    w_rsp_rdata_nx = r_rsp_rdata;
    w_rsp_err_nx   = r_rsp_err;
    w_mem_we       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_req_ready_nx = 1'b1;
        if (r_req_ready && req_valid) begin
          w_req_nx.we    = req_we;
          w_req_nx.addr  = req_addr;
          w_req_nx.wdata = req_wdata;
          w_req_nx.size  = req_size;
          w_req_ready_nx = 1'b0;
          w_cnt_nx       = CW'(WAIT_CYCLES);
          w_state_nx     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nx     = ST_RESP;
          w_rsp_valid_nx = 1'b1;
          w_rsp_err_nx   = w_err;
          w_rsp_rdata_nx = (w_err || r_req.we) ? '0 : w_rdata;
          w_mem_we       = r_req.we & ~w_err;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nx     = ST_IDLE;
          w_rsp_valid_nx = 1'b0;
          w_rsp_rdata_nx = '0;
          w_rsp_err_nx   = 1'b0;
          w_req_ready_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // RAM contents survive reset; writes only fire on the access edge.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: scoreboard of expected responses,
// latency/handshake checks, plus a zero-wait-state instance.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_rsp_ready;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] size, input logic [31:0] exp_rd,
                        input logic exp_err, input int hold);
    int    n;
    exp_t  e;
    exp_t  got;
    string t;
    t = $sformatf("we%0b sz%0d @%h", we, size, addr);
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({t, " accept_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    chk({t, " busy_ready"}, 32'(req_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({t, " latency"}, 32'(n), 32'd3);
    got = sb.pop_front();
    chk({t, " rdata"}, rsp_rdata, got.rdata);
    chk({t, " err"}, 32'(rsp_err), 32'(got.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({t, " bp_valid"}, 32'(rsp_valid), 32'd1);
      chk({t, " bp_rdata"}, rsp_rdata, got.rdata);
      chk({t, " bp_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({t, " hs_valid"}, 32'(rsp_valid), 32'd0);
    chk({t, " hs_ready"}, 32'(req_ready), 32'd1);
    chk({t, " hs_rdata"}, rsp_rdata, 32'd0);
  endtask

  task automatic zreq(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] size, input logic [31:0] exp_rd);
    int n;
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; z_req_valid = 1'b1;
    n = 0;
    while (!z_req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("z accept_ready", 32'(z_req_ready), 32'd1);
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    n = 0;
    while (!z_rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("z latency", 32'(n), 32'd1);
    chk("z rdata", z_rsp_rdata, exp_rd);
    chk("z err", 32'(z_rsp_err), 32'd0);
    z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    z_rsp_ready = 1'b0;
    chk("z hs_ready", 32'(z_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 3'b010; rsp_ready = 1'b0; z_req_valid = 1'b0; z_rsp_ready = 1'b0;

    // Reset held for three cycles, then released between edges.
    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("release ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("release ready_high", 32'(req_ready), 32'd1);

    // Word store/load and extension of sub-word loads.
    do_req(1'b1, 32'h10, 32'h8000_00FF, 3'b010, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 32'h8000_00FF, 1'b0, 0);
    do_req(1'b0, 32'h10, 32'h0, 3'b000, 32'hFFFF_FFFF, 1'b0, 0);
    do_req(1'b0, 32'h10, 32'h0, 3'b100, 32'h0000_00FF, 1'b0, 0);
    do_req(1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF_8000, 1'b0, 0);
    do_req(1'b0, 32'h12, 32'h0, 3'b101, 32'h0000_8000, 1'b0, 0);

    // Error cases must not disturb memory.
    do_req(1'b0, 32'h11, 32'h0, 3'b010, 32'h0, 1'b1, 0);
    do_req(1'b0, 32'h13, 32'h0, 3'b001, 32'h0, 1'b1, 0);
    do_req(1'b1, 32'd4096, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b1, 0);
    do_req(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 0);
    do_req(1'b1, 32'h10, 32'h0000_0011, 3'b100, 32'h0, 1'b1, 0);
    do_req(1'b1, 32'h10, 32'h0000_2222, 3'b101, 32'h0, 1'b1, 0);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 32'h8000_00FF, 1'b0, 0);

    // Response backpressure.
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 32'h8000_00FF, 1'b0, 5);

    // Partial-lane stores leave the other bytes intact.
    do_req(1'b1, 32'h30, 32'h1122_3344, 3'b010, 32'h0, 1'b0, 0);
    do_req(1'b1, 32'h31, 32'hFFFF_FFAA, 3'b000, 32'h0, 1'b0, 0);
    do_req(1'b1, 32'h32, 32'h5555_BEEF, 3'b001, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h30, 32'h0, 3'b010, 32'hBEEF_AA44, 1'b0, 0);
    do_req(1'b0, 32'h33, 32'h0, 3'b000, 32'hFFFF_FFBE, 1'b0, 0);
    do_req(1'b0, 32'h30, 32'h0, 3'b101, 32'h0000_AA44, 1'b0, 0);
    do_req(1'b0, 32'h30, 32'h0, 3'b001, 32'hFFFF_AA44, 1'b0, 0);
    do_req(1'b0, 32'h30, 32'h0, 3'b000, 32'h0000_0044, 1'b0, 0);

    // Reset during WAIT discards the pending store.
    do_req(1'b1, 32'h20, 32'hCAFE_F00D, 3'b010, 32'h0, 1'b0, 0);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_size = 3'b010;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort accepted", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort req_ready", 32'(req_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort held_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort ready_back", 32'(req_ready), 32'd1);
    do_req(1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFE_F00D, 1'b0, 0);

    // Zero-wait-state instance.
    zreq(1'b1, 32'h40, 32'h0BAD_BEEF, 3'b010, 32'h0);
    zreq(1'b0, 32'h40, 32'h0, 3'b010, 32'h0BAD_BEEF);
    zreq(1'b0, 32'h42, 32'h0, 3'b101, 32'h0000_0BAD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
